sio_device: RTL and testbench

Remote end of the SIO nibble link: receives 64-cycle host frames (write/read command, 16-bit stream word, CRC-16), performs the command on a simple local register bus, and returns a response frame (stream word, 32-bit read data, CRC-16) in the same frame period. It sits in the remote-IO board FPGA between the link SERDES and the board register file.

---
 rtl/sio_device_pkg.sv | 47 ++++
 rtl/crc_16_4_usb.sv | 20 ++
 rtl/sio_device.sv | 175 +++++++++++++++++
 tb/tb_sio_device.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sio_device_pkg.sv
// Shared definitions for the SIO nibble-link remote device: frame layout,
// link symbols, state encoding and the CRC-16/USB nibble step.
package sio_device_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_CHECK,
        ST_RESP,
        ST_TX
    } state_t;

    localparam logic [3:0] NIB_IDLE  = 4'hF;
    localparam logic [3:0] NIB_START = 4'h0;
    localparam logic [2:0] IDLE_MIN  = 3'd4;

    // Receive frame nibble indices, relative to the start nibble at t=0
    localparam logic [6:0] T_DATA_FIRST  = 7'd1;
    localparam logic [6:0] T_DATA_LAST   = 7'd20;
    localparam logic [6:0] T_STREAM_LAST = 7'd24;
    localparam logic [6:0] T_CRC_LAST    = 7'd28;
    localparam logic [6:0] T_CHECK       = 7'd29;
    localparam logic [6:0] T_RESP_FIRST  = 7'd30;

    // Response nibble indices, relative to the response start nibble
    localparam logic [6:0] TX_STREAM = 7'd1;
    localparam logic [6:0] TX_RDATA  = 7'd5;
    localparam logic [6:0] TX_CRC    = 7'd13;
    localparam logic [6:0] TX_END    = 7'd17;

    localparam logic [11:0] NOP_ADDR        = 12'hFFF;
    localparam logic [31:0] RD_TIMEOUT_FILL = 32'hFFFF_FFFF;
    localparam logic [15:0] CRC_INIT        = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL   = 16'hA001;

    // Reflected CRC-16 (poly 0x8005), nibble bits consumed LSB first
    function automatic logic [15:0] crc16_nibble(input logic [15:0] crc, input logic [3:0] nib);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else               c = c >> 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/crc_16_4_usb.sv
// CRC-16/USB accumulator taking one nibble per cycle; the transmitted
// check value is the bitwise complement of the register.
module crc_16_4_usb
    import sio_device_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        en,
    input  logic [3:0]  d,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    crc <= CRC_INIT;
        else if (init) crc <= CRC_INIT;
        else if (en)   crc <= crc16_nibble(crc, d);
    end

endmodule

// File: rtl/sio_device.sv
// SIO link remote end: decodes a host frame, runs one register-bus command
// and returns stream word plus read data in the same frame period.
module sio_device
    import sio_device_pkg::*;
#(
    parameter int unsigned RESP_OFFSET = 32,
    parameter int unsigned RD_TIMEOUT  = 36
) (
    input  logic        c,
    input  logic        rn,
    input  logic [3:0]  rd,
    output logic [3:0]  td,
    output logic [11:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    input  logic [15:0] stream_out,
    output logic [15:0] stream_in,
    output logic [15:0] crc_failcount
);

    localparam logic [6:0] T_TX      = 7'(RESP_OFFSET);
    localparam logic [6:0] T_TIMEOUT = 7'(RD_TIMEOUT);

    state_t        state;
    logic [6:0]    t;
    logic [2:0]    idle_cnt;
    logic [107:0]  sh;
    logic [31:0]   rdata;
    logic          rdata_got;
    logic [15:0]   tx_stream;
    logic [15:0]   rx_crc;
    logic [15:0]   tx_crc;

    logic [111:0]  frame;
    logic          crc_good;
    logic          rx_start, rx_en, tx_init, tx_en;
    logic          cap_now;
    logic [31:0]   rdata_cur;
    logic [6:0]    k;
    logic [47:0]   payload;
    logic [15:0]   crc_out;
    logic [5:0]    pidx;
    logic [3:0]    cidx;
    logic [3:0]    tx_nib;

    always_comb begin
        frame    = {rd, sh};
        crc_good = (frame[111:96] == ~rx_crc);
        rx_start = (state == ST_IDLE) && (rd == NIB_START) && (idle_cnt >= IDLE_MIN);
        rx_en    = (state == ST_RX) && (t <= T_STREAM_LAST);
        cap_now  = (state == ST_RESP || state == ST_TX) && !rdata_got && bus_rvalid &&
                   (t >= T_RESP_FIRST) && (t <= T_TIMEOUT);
        // A strobe on the last accepted cycle must reach the first rdata nibble directly
        rdata_cur = cap_now ? bus_rdata : rdata;
        k         = t + 7'd1 - T_TX;
        payload   = {rdata_cur, (t == T_TX) ? stream_out : tx_stream};
        crc_out   = ~tx_crc;
        pidx      = 6'({k - TX_STREAM, 2'b00});
        cidx      = 4'({k - TX_CRC, 2'b00});
        tx_nib    = NIB_IDLE;
        if (k >= TX_STREAM && k < TX_CRC) tx_nib = payload[pidx +: 4];
        else if (k >= TX_CRC && k < TX_END) tx_nib = crc_out[cidx +: 4];
        tx_init   = (state == ST_RESP) && (t == T_TX - 7'd1);
        tx_en     = (state == ST_TX) && (k >= TX_STREAM) && (k < TX_CRC);
    end

    crc_16_4_usb u_crc_rx (
        .clk   (c),
        .rst_n (rn),
        .init  (rx_start),
        .en    (rx_en),
        .d     (rd),
        .crc   (rx_crc)
    );

    crc_16_4_usb u_crc_tx (
        .clk   (c),
        .rst_n (rn),
        .init  (tx_init),
        .en    (tx_en),
        .d     (tx_nib),
        .crc   (tx_crc)
    );

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            state         <= ST_IDLE;
            t             <= '0;
            idle_cnt      <= '0;
            sh            <= '0;
            rdata         <= '0;
            rdata_got     <= 1'b1;
            tx_stream     <= '0;
            td            <= NIB_IDLE;
            bus_addr      <= '0;
            bus_wdata     <= '0;
            bus_we        <= 1'b0;
            bus_re        <= 1'b0;
            stream_in     <= '0;
            crc_failcount <= '0;
        end else begin
            bus_we <= 1'b0;
            bus_re <= 1'b0;
            if (cap_now) begin
                rdata     <= bus_rdata;
                rdata_got <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    td <= NIB_IDLE;
                    if (rx_start) begin
                        state    <= ST_RX;
                        t        <= T_DATA_FIRST;
                        idle_cnt <= '0;
                    end else if (rd == NIB_IDLE) begin
                        if (idle_cnt < IDLE_MIN) idle_cnt <= idle_cnt + 3'd1;
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                ST_RX: begin
                    sh <= frame[111:4];
                    t  <= t + 7'd1;
                    // The frame is judged on the edge that consumes the last CRC nibble
                    if (t == T_CRC_LAST) begin
                        if (crc_good) begin
                            state     <= ST_CHECK;
                            stream_in <= frame[95:80];
                            bus_addr  <= frame[75:64];
                            bus_wdata <= frame[63:0];
                            if (frame[79]) begin
                                bus_we    <= (frame[75:64] != NOP_ADDR);
                                rdata     <= '0;
                                rdata_got <= 1'b1;
                            end else begin
                                bus_re    <= 1'b1;
                                rdata     <= RD_TIMEOUT_FILL;
                                rdata_got <= 1'b0;
                            end
                        end else begin
                            state         <= ST_IDLE;
                            idle_cnt      <= '0;
                            crc_failcount <= crc_failcount + 16'd1;
                        end
                    end
                end
                ST_CHECK: begin
                    state <= ST_RESP;
                    t     <= t + 7'd1;
                end
                ST_RESP: begin
                    t <= t + 7'd1;
                    if (tx_init) begin
                        td    <= NIB_START;
                        state <= ST_TX;
                    end
                end
                ST_TX: begin
                    t <= t + 7'd1;
                    if (t == T_TX) tx_stream <= stream_out;
                    td <= tx_nib;
                    if (k == TX_END) begin
                        state    <= ST_IDLE;
                        idle_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sio_device.sv
// Directed bench for sio_device: a frame-level model predicts every output
// cycle by cycle and one negedge process compares the DUT against it.
module tb_sio_device;

    logic        c = 1'b0;
    logic        rn = 1'b1;
    logic [3:0]  rd = 4'hF;
    logic [3:0]  td;
    logic [11:0] bus_addr;
    logic [63:0] bus_wdata;
    logic        bus_we, bus_re;
    logic [31:0] bus_rdata = '0;
    logic        bus_rvalid = 1'b0;
    logic [15:0] stream_out = '0;
    logic [15:0] stream_in;
    logic [15:0] crc_failcount;

    sio_device #(.RESP_OFFSET(32), .RD_TIMEOUT(36)) dut (
        .c             (c),
        .rn            (rn),
        .rd            (rd),
        .td            (td),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_we        (bus_we),
        .bus_re        (bus_re),
        .bus_rdata     (bus_rdata),
        .bus_rvalid    (bus_rvalid),
        .stream_out    (stream_out),
        .stream_in     (stream_in),
        .crc_failcount (crc_failcount)
    );

    always #5 c = ~c;

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    int          e_t = -1;
    logic [3:0]  e_td = 4'hF;
    logic        e_we = 1'b0, e_re = 1'b0;
    logic [11:0] e_addr = '0;
    logic [63:0] e_wdata = '0;
    logic [15:0] e_sin = '0;
    logic [15:0] e_fail = '0;
    logic [3:0]  cap_td [0:63];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h want %0h", name, e_t, act, exp);
        end
    endfunction

    // CRC-16/USB over a nibble stream, each nibble LSB first; returns the complemented value
    function automatic logic [15:0] crc16_usb(input logic [3:0] q[$]);
        logic [15:0] r;
        logic fb;
        r = 16'hFFFF;
        foreach (q[i]) begin
            for (int b = 0; b < 4; b++) begin
                fb = r[0] ^ q[i][b];
                r  = r >> 1;
                if (fb) r = r ^ 16'hA001;
            end
        end
        return ~r;
    endfunction

    always @(negedge c) begin
        if (chk_en) begin
            chk("td", 64'(td), 64'(e_td));
            chk("bus_we", 64'(bus_we), 64'(e_we));
            chk("bus_re", 64'(bus_re), 64'(e_re));
            chk("stream_in", 64'(stream_in), 64'(e_sin));
            chk("crc_failcount", 64'(crc_failcount), 64'(e_fail));
            if (e_we || e_re) chk("bus_addr", 64'(bus_addr), 64'(e_addr));
            if (e_we) chk("bus_wdata", bus_wdata, e_wdata);
            if (e_t >= 0 && e_t < 64) cap_td[e_t] = td;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge c); #1;
            rd = 4'hF; bus_rvalid = 1'b0;
            e_t = -1; e_td = 4'hF; e_we = 1'b0; e_re = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [79:0] cmd, input logic [15:0] strm, input logic [15:0] sout,
                             input int rv1, input logic [31:0] d1, input int rv2, input logic [31:0] d2,
                             input int flip, input int rst_at);
        logic [3:0]  rx [0:28];
        logic [3:0]  tx [0:16];
        logic [3:0]  q[$];
        logic [15:0] crc;
        logic [31:0] rdat;
        logic [47:0] pay;
        logic        good, is_wr, nop, aborted;
        rx[0] = 4'h0;
        for (int i = 0; i < 20; i++) rx[1 + i] = cmd[4*i +: 4];
        for (int i = 0; i < 4; i++)  rx[21 + i] = strm[4*i +: 4];
        q = {};
        for (int i = 1; i <= 24; i++) q.push_back(rx[i]);
        crc = crc16_usb(q);
        for (int i = 0; i < 4; i++) rx[25 + i] = crc[4*i +: 4];
        if (flip >= 0) rx[1 + flip/4][flip%4] = ~rx[1 + flip/4][flip%4];
        good  = (flip < 0);
        is_wr = cmd[79];
        nop   = is_wr && (cmd[75:64] == 12'hFFF);
        if (is_wr)                      rdat = 32'h0;
        else if (rv1 >= 30 && rv1 <= 36) rdat = d1;
        else if (rv2 >= 30 && rv2 <= 36) rdat = d2;
        else                            rdat = 32'hFFFF_FFFF;
        pay   = {rdat, sout};
        tx[0] = 4'h0;
        q = {};
        for (int i = 0; i < 12; i++) begin
            tx[1 + i] = pay[4*i +: 4];
            q.push_back(tx[1 + i]);
        end
        crc = crc16_usb(q);
        for (int i = 0; i < 4; i++) tx[13 + i] = crc[4*i +: 4];
        for (int i = 0; i < 64; i++) cap_td[i] = 4'hx;
        stream_out = sout;
        e_addr  = cmd[75:64];
        e_wdata = cmd[63:0];
        aborted = 1'b0;
        for (int t = 0; t <= 52; t++) begin
            @(posedge c); #1;
            if (t == rst_at) begin
                rn = 1'b0; aborted = 1'b1; e_sin = '0; e_fail = '0;
            end
            if (aborted && t == rst_at + 3) rn = 1'b1;
            if (aborted) rd = (t == rst_at + 3) ? 4'h0 : 4'hF;
            else         rd = (t <= 28) ? rx[t] : 4'hF;
            bus_rvalid = !aborted && (t == rv1 || t == rv2);
            bus_rdata  = (t == rv1) ? d1 : (t == rv2) ? d2 : 32'h5A5A_5A5A;
            e_t  = t;
            e_td = (!aborted && good && t >= 32 && t <= 48) ? tx[t - 32] : 4'hF;
            e_we = !aborted && good && t == 29 && is_wr && !nop;
            e_re = !aborted && good && t == 29 && !is_wr;
            if (!aborted && t == 29) begin
                if (good) e_sin = strm;
                else      e_fail = e_fail + 16'd1;
            end
        end
        idle(6);
    endtask

    initial begin
        logic [3:0]  pin_q[$];
        logic [7:0]  ch;
        logic [3:0]  exp2 [0:11];
        string       s;
        #1 rn = 1'b0;
        #2 chk_en = 1'b1;
        repeat (3) @(posedge c);
        #1 rn = 1'b1;
        idle(6);

        s = "123456789";
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            pin_q.push_back(ch[3:0]);
            pin_q.push_back(ch[7:4]);
        end
        chk("crc_model_pin", 64'(crc16_usb(pin_q)), 64'h B4C8);

        run_frame({1'b1, 3'b000, 12'h123, 64'h0123_4567_89AB_CDEF}, 16'hA5A5, 16'h5555,
                  -1, '0, -1, '0, -1, -1);

        run_frame({1'b0, 3'b000, 12'h010, 64'h0}, 16'h0F0F, 16'h1234,
                  31, 32'hCAFE_F00D, 33, 32'h1111_1111, -1, -1);
        exp2 = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hD, 4'h0, 4'h0, 4'hF, 4'hE, 4'hF, 4'hA, 4'hC};
        for (int i = 0; i < 12; i++) chk("resp_literal", 64'(cap_td[33 + i]), 64'(exp2[i]));

        run_frame({1'b0, 3'b101, 12'h020, 64'hFFFF_0000_FFFF_0000}, 16'h3C3C, 16'h0000,
                  37, 32'h1234_5678, -1, '0, -1, -1);
        for (int i = 37; i <= 44; i++) chk("timeout_fill", 64'(cap_td[i]), 64'h F);

        run_frame({1'b0, 3'b000, 12'h7FE, 64'h0}, 16'h1357, 16'h9ABC,
                  29, 32'hBAD0_BAD0, 30, 32'h0BAD_F00D, -1, -1);

        run_frame({1'b0, 3'b000, 12'h801, 64'h0}, 16'h2468, 16'hFEDC,
                  36, 32'h8765_4321, -1, '0, -1, -1);

        run_frame({1'b1, 3'b000, 12'h055, 64'hDEAD_BEEF_0000_0001}, 16'hBEEF, 16'h1111,
                  -1, '0, -1, '0, 5, -1);
        chk("failcount_after_flip", 64'(crc_failcount), 64'd1);

        run_frame('1, 16'h7E7E, 16'hC3C3, -1, '0, -1, '0, -1, -1);

        run_frame({1'b0, 3'b000, 12'h010, 64'h0}, 16'h9999, 16'h4444,
                  31, 32'h0000_0001, -1, '0, -1, 10);
        run_frame({1'b1, 3'b000, 12'h0AB, 64'h5555_AAAA_1234_8765}, 16'h2222, 16'h6789,
                  -1, '0, -1, '0, -1, -1);
        chk("stream_in_after_reset", 64'(stream_in), 64'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
